// File: rtl/nios_mult_seq.sv
// Sequential 32x32 multiplier for MUL/MULXUU/MULXSU/MULXSS built on an external
// unsigned 16x16 registered multiplier cell that returns products MUL_LAT cycles after issue.
module nios_mult_seq #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p
);

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } op_t;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIX, S_DONE} state_t;

    state_t       state_q;
    op_t          op_q;
    logic [31:0]  a_q, b_q;
    logic [63:0]  acc_q;
    logic [1:0]   iss_q;
    logic         busy_q, done_q, mul_en_q;
    logic [31:0]  result_q;
    logic [15:0]  mul_a_q, mul_b_q;
    logic [MUL_LAT-1:0] dl_v_q;
    logic [1:0]   dl_idx_q [MUL_LAT];

    logic [1:0]   last_idx, iss_d, cap_idx;
    logic         cap_v;
    logic [5:0]   cap_sh;
    logic [63:0]  acc_d;
    logic [31:0]  corr, hi_fix_d;
    logic [15:0]  mul_a_d, mul_b_d;

    // Pair index bit 1 selects the upper half of a, bit 0 the upper half of b.
    always_comb begin
        last_idx = (op_q == OP_MUL) ? 2'd2 : 2'd3;
        iss_d    = iss_q + 2'd1;
        mul_a_d  = iss_d[1] ? a_q[31:16] : a_q[15:0];
        mul_b_d  = iss_d[0] ? b_q[31:16] : b_q[15:0];
        cap_v    = dl_v_q[MUL_LAT-1];
        cap_idx  = dl_idx_q[MUL_LAT-1];
        cap_sh   = {cap_idx[1] & cap_idx[0], cap_idx[1] ^ cap_idx[0], 4'b0000};
        acc_d    = acc_q + ({32'b0, mul_p} << cap_sh);
    end

    // Signed corrections applied to the unsigned high word.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        corr = '0;
        case (op_q)
            OP_MULXSS: corr = (a_q[31] ? b_q : 32'b0) + (b_q[31] ? a_q : 32'b0);
            OP_MULXSU: corr = a_q[31] ? b_q : 32'b0;
            default:   corr = '0;
        endcase
        hi_fix_d = acc_q[63:32] - corr;
    end

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous: reset_n is only acted on at a rising clk edge.
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            iss_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            mul_en_q <= 1'b0;
            result_q <= '0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            dl_v_q   <= '0;
            for (int i = 0; i < MUL_LAT; i++) dl_idx_q[i] <= '0;
        end else begin
            // Delay line tracks in-flight cell products independently of the FSM state.
            dl_v_q[0]   <= mul_en_q;
            dl_idx_q[0] <= iss_q;
            for (int i = 1; i < MUL_LAT; i++) begin
                dl_v_q[i]   <= dl_v_q[i-1];
                dl_idx_q[i] <= dl_idx_q[i-1];
            end
            if (cap_v) acc_q <= acc_d;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= op_t'(op);
                        a_q      <= src1;
                        b_q      <= src2;
                        acc_q    <= '0;
                        iss_q    <= '0;
                        busy_q   <= 1'b1;
                        mul_en_q <= 1'b1;
                        mul_a_q  <= src1[15:0];
                        mul_b_q  <= src2[15:0];
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (iss_q == last_idx) begin
                        mul_en_q <= 1'b0;
                        mul_a_q  <= '0;
                        mul_b_q  <= '0;
                        state_q  <= S_WAIT;
                    end else begin
                        iss_q   <= iss_d;
                        mul_a_q <= mul_a_d;
                        mul_b_q <= mul_b_d;
                    end
                end
                S_WAIT: begin
                    if (cap_v && cap_idx == last_idx) state_q <= S_FIX;
                end
                S_FIX: begin
                    acc_q[63:32] <= hi_fix_d;
                    result_q     <= (op_q == OP_MUL) ? acc_q[31:0] : hi_fix_d;
                    done_q       <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;
    assign mul_en = mul_en_q;

endmodule

// File: tb/tb_nios_mult_seq.sv
// Directed bench for nios_mult_seq: one instance with MUL_LAT=1 and one with MUL_LAT=3,
// each driving its own behavioural model of the registered 16x16 multiplier cell.
module tb_nios_mult_seq;

    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_XUU = 2'b01;
    localparam logic [1:0] OP_XSU = 2'b10;
    localparam logic [1:0] OP_XSS = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start_s  [2];
    logic [1:0]  op_s     [2];
    logic [31:0] src1_s   [2];
    logic [31:0] src2_s   [2];
    logic        busy_s   [2];
    logic        done_s   [2];
    logic [31:0] result_s [2];
    logic [15:0] mul_a_s  [2];
    logic [15:0] mul_b_s  [2];
    logic        mul_en_s [2];

    int n_tests = 0;
    int n_fail  = 0;
    int done_at;
    logic [31:0] res;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_u
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] pipe [LAT];

        always @(posedge clk) begin
            if (mul_en_s[g]) pipe[0] <= mul_a_s[g] * mul_b_s[g];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end

        nios_mult_seq #(.MUL_LAT(LAT)) u_dut (
            .clk    (clk),
            .reset_n(reset_n),
            .start  (start_s[g]),
            .op     (op_s[g]),
            .src1   (src1_s[g]),
            .src2   (src2_s[g]),
            .busy   (busy_s[g]),
            .done   (done_s[g]),
            .result (result_s[g]),
            .mul_a  (mul_a_s[g]),
            .mul_b  (mul_b_s[g]),
            .mul_en (mul_en_s[g]),
            .mul_p  (pipe[LAT-1])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 (start high). Returns in the
    // cycle after done so a back-to-back start can be issued immediately.
    task automatic run_op(input int u, input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_done);
        int          d_at   = -1;
        int          ab_bad = 0;
        logic [31:0] mask   = '0;
        logic [31:0] r      = '0;
        start_s[u] = 1'b1;
        op_s[u]    = op;
        src1_s[u]  = a;
        src2_s[u]  = b;
        for (int c = 0; c < 24 && d_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) check($sformatf("%s idle_busy", tag), 32'(busy_s[u]), 32'd0);
            if (mul_en_s[u]) mask[c] = 1'b1;
            else if (mul_a_s[u] != 16'd0 || mul_b_s[u] != 16'd0) ab_bad++;
            if (done_s[u]) begin
                d_at = c;
                r    = result_s[u];
            end
            @(posedge clk);
            #1;
            if (c == 0) begin
                start_s[u] = 1'b0;
                op_s[u]    = ~op;
                src1_s[u]  = $urandom;
                src2_s[u]  = $urandom;
            end
            if (c == 2) start_s[u] = 1'b1;
            if (c == 3) start_s[u] = 1'b0;
        end
        check($sformatf("%s done_cycle", tag), 32'(d_at), 32'(exp_done));
        check($sformatf("%s result", tag), r, exp_res);
        check($sformatf("%s mul_en_cycles", tag), mask,
              (op == OP_MUL) ? 32'h0000_000E : 32'h0000_001E);
        check($sformatf("%s ab_zero_when_idle", tag), 32'(ab_bad), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            start_s[u] = 1'b1;
            op_s[u]    = OP_XUU;
            src1_s[u]  = 32'h1234_5678;
            src2_s[u]  = 32'h9ABC_DEF0;
        end

        // Start held high during reset must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("rst u%0d busy", u), 32'(busy_s[u]), 32'd0);
            check($sformatf("rst u%0d done", u), 32'(done_s[u]), 32'd0);
            check($sformatf("rst u%0d mul_en", u), 32'(mul_en_s[u]), 32'd0);
            check($sformatf("rst u%0d mul_ab", u), {mul_a_s[u], mul_b_s[u]}, 32'd0);
            check($sformatf("rst u%0d result", u), result_s[u], 32'd0);
        end
        start_s[1] = 1'b0;

        // MUL_LAT = 1: first start in the first cycle out of reset, then back-to-back ops.
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_op(0, "l1 mul 3x5",      OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 6);
        run_op(0, "l1 xuu ffxff",    OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 7);
        run_op(0, "l1 xss ffxff",    OP_XSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 7);
        run_op(0, "l1 xsu ffxff",    OP_XSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7);
        run_op(0, "l1 mul 2^16sq",   OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 6);
        run_op(0, "l1 xuu 2^16sq",   OP_XUU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 7);
        run_op(0, "l1 xss -2x3",     OP_XSS, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 7);
        run_op(0, "l1 mul 1234x10",  OP_MUL, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 6);
        run_op(0, "l1 xuu 1234x10",  OP_XUU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 7);

        // MUL_LAT = 3.
        @(posedge clk);
        #1;
        run_op(1, "l3 mul 3x5",      OP_MUL, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 8);
        run_op(1, "l3 xuu ffxff",    OP_XUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 9);

        // MUL_LAT = 3, start held high through busy: a second op is accepted in cycle 10.
        @(posedge clk);
        #1;
        start_s[1] = 1'b1;
        op_s[1]    = OP_XSS;
        src1_s[1]  = 32'h8000_0000;
        src2_s[1]  = 32'h7FFF_FFFF;
        done_at    = -1;
        res        = '0;
        for (int c = 0; c < 24 && done_at < 0; c++) begin
            @(negedge clk);
            if (done_s[1]) begin
                done_at = c;
                res     = result_s[1];
            end
            @(posedge clk);
            #1;
        end
        check("hold first done_cycle", 32'(done_at), 32'd9);
        check("hold first result", res, 32'hC000_0000);
        @(negedge clk);
        check("hold cycle10 busy", 32'(busy_s[1]), 32'd0);
        @(posedge clk);
        #1;
        start_s[1] = 1'b0;
        @(negedge clk);
        check("hold cycle11 busy", 32'(busy_s[1]), 32'd1);
        done_at = -1;
        for (int c = 12; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (done_s[1]) begin
                done_at = c;
                res     = result_s[1];
            end
        end
        check("hold second done_cycle", 32'(done_at), 32'd19);
        check("hold second result", res, 32'hC000_0000);

        // Reset asserted in cycle 3 of an operation on the MUL_LAT = 1 instance.
        @(posedge clk);
        #1;
        start_s[0] = 1'b1;
        op_s[0]    = OP_XUU;
        src1_s[0]  = 32'hFFFF_FFFF;
        src2_s[0]  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort busy", 32'(busy_s[0]), 32'd0);
        check("abort mul_en", 32'(mul_en_s[0]), 32'd0);
        check("abort done", 32'(done_s[0]), 32'd0);
        check("abort result", result_s[0], 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_op(0, "post-rst xss", OP_XSS, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
